if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 140 ++++++++++++++
 tb/tb_if_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, imem handshake, skid buffer, IF/ID register.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_write,
  input  logic                  IF_ID_write,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]   IF_ID_pc,
  output logic [INST_WIDTH-1:0] IF_ID_inst,
  output logic                  IF_ID_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,output logic [31:0]          stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {BOOT, FETCH, HELD} state_t;

  state_t                  state, state_nxt;
  logic [PC_WIDTH-1:0]     pc, pc_nxt;
  logic                    drop, drop_nxt;
  logic [PC_WIDTH-1:0]     drop_addr, drop_addr_nxt;
  logic [PC_WIDTH-1:0]     skid_pc, skid_pc_nxt;
  logic [INST_WIDTH-1:0]   skid_inst, skid_inst_nxt;
  logic [PC_WIDTH-1:0]     id_pc_nxt;
  logic [INST_WIDTH-1:0]   id_inst_nxt;
  logic                    id_valid_nxt;
  logic                    ack_fire;
  logic [PC_WIDTH-1:0]     pc_inc;

  // While a dropped request is still in flight, the bus must keep showing its address.
  assign imem_req  = (state == FETCH);
  assign imem_addr = drop ? drop_addr : pc;
  assign ack_fire  = (state == FETCH) && imem_ack;
  assign pc_inc    = pc + PC_WIDTH'(4);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_nxt      = drop;
    drop_addr_nxt = drop_addr;
    skid_pc_nxt   = skid_pc;
    skid_inst_nxt = skid_inst;
    id_pc_nxt     = IF_ID_pc;
    id_inst_nxt   = IF_ID_inst;
    id_valid_nxt  = IF_ID_valid;

    if (branch_taken) begin
      // An unanswered request cannot be cancelled on the bus, so remember to discard its ack.
      drop_nxt      = (state == FETCH) && !imem_ack;
      drop_addr_nxt = drop ? drop_addr : pc;
      pc_nxt        = branch_target;
      id_pc_nxt     = '0;
      id_inst_nxt   = NOP;
      id_valid_nxt  = 1'b0;
      state_nxt     = FETCH;
    end else if (ack_fire && drop) begin
      drop_nxt = 1'b0;
      if (IF_ID_write) begin
        id_pc_nxt    = '0;
        id_inst_nxt  = NOP;
        id_valid_nxt = 1'b0;
      end
    end else if (ack_fire) begin
      if (IF_ID_write) begin
        id_pc_nxt    = pc;
        id_inst_nxt  = imem_rdata;
        id_valid_nxt = 1'b1;
      end else begin
        skid_pc_nxt   = pc;
        skid_inst_nxt = imem_rdata;
        state_nxt     = HELD;
      end
      if (pc_write) pc_nxt = pc_inc;
    end else if (state == HELD) begin
      if (IF_ID_write) begin
        id_pc_nxt    = skid_pc;
        id_inst_nxt  = skid_inst;
        id_valid_nxt = 1'b1;
        state_nxt    = FETCH;
      end
    end else begin
      if (IF_ID_write) begin
        id_pc_nxt    = '0;
        id_inst_nxt  = NOP;
        id_valid_nxt = 1'b0;
      end
      if (state == BOOT) state_nxt = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      drop_addr   <= RESET_PC;
      skid_pc     <= '0;
      skid_inst   <= NOP;
      IF_ID_pc    <= '0;
      IF_ID_inst  <= NOP;
      IF_ID_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop        <= drop_nxt;
      drop_addr   <= drop_addr_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_inst   <= skid_inst_nxt;
      IF_ID_pc    <= id_pc_nxt;
      IF_ID_inst  <= id_inst_nxt;
      IF_ID_valid <= id_valid_nxt;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!IF_ID_write && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized checks of if_stage against a transaction-level model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1;
  logic        IF_ID_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid)
  );

  always #5 clk = ~clk;

  // Reference model: where the fetch stream stands, what is parked, what the decoder sees.
  bit          m_booting, m_drop;
  logic [31:0] m_next_fetch, m_inflight_addr;
  logic [31:0] m_parked[$];
  logic [31:0] m_parked_inst[$];
  logic [31:0] m_id_pc, m_id_inst;
  logic        m_id_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  function automatic bit m_req();
    return !m_booting && (m_parked.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drop ? m_inflight_addr : m_next_fetch;
  endfunction

  task automatic model_reset();
    m_booting = 1; m_drop = 0; m_next_fetch = 32'h0; m_inflight_addr = 32'h0;
    m_parked.delete(); m_parked_inst.delete();
    m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
  endtask

  task automatic bubble_if_open();
    if (IF_ID_write) begin m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0; end
  endtask

  task automatic model_step();
    bit answered;
    if (!rst_n) begin model_reset(); return; end
    answered = m_req() && imem_ack;
    if (branch_taken) begin
      if (m_req() && !answered && !m_drop) m_inflight_addr = m_next_fetch;
      m_drop = m_req() && !answered;
      m_next_fetch = branch_target;
      m_parked.delete(); m_parked_inst.delete();
      m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
      m_booting = 0;
    end else if (answered && m_drop) begin
      m_drop = 0;
      bubble_if_open();
    end else if (answered) begin
      if (IF_ID_write) begin
        m_id_pc = m_next_fetch; m_id_inst = imem_rdata; m_id_valid = 1;
      end else begin
        m_parked.push_back(m_next_fetch); m_parked_inst.push_back(imem_rdata);
      end
      if (pc_write) m_next_fetch = m_next_fetch + 32'd4;
    end else if (m_parked.size() != 0) begin
      if (IF_ID_write) begin
        m_id_pc = m_parked.pop_front(); m_id_inst = m_parked_inst.pop_front(); m_id_valid = 1;
      end
    end else begin
      bubble_if_open();
      m_booting = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},   64'(imem_req),    64'(m_req()));
    chk({tag, ".addr"},  64'(imem_addr),   64'(m_addr()));
    chk({tag, ".pc"},    64'(IF_ID_pc),    64'(m_id_pc));
    chk({tag, ".inst"},  64'(IF_ID_inst),  64'(m_id_inst));
    chk({tag, ".valid"}, 64'(IF_ID_valid), 64'(m_id_valid));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle();
    imem_ack = 0; branch_taken = 0; pc_write = 1; IF_ID_write = 1;
  endtask

  task automatic zero_wait_ack();
    imem_ack = 1; imem_rdata = mem_word(imem_addr);
  endtask

  initial begin
    int wait_left;
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst.req", 64'(imem_req), 64'd0);
    chk("rst.addr", 64'(imem_addr), 64'h0);
    chk("rst.pc", 64'(IF_ID_pc), 64'h0);
    chk("rst.inst", 64'(IF_ID_inst), 64'(NOP));
    chk("rst.valid", 64'(IF_ID_valid), 64'd0);

    rst_n = 1;
    chk("boot.req", 64'(imem_req), 64'd0);
    cycle("boot");
    chk("first.req", 64'(imem_req), 64'd1);
    chk("first.addr", 64'(imem_addr), 64'h0);
    imem_ack = 1; imem_rdata = 32'h0010_0093;
    cycle("first_ack");
    chk("first.id_pc", 64'(IF_ID_pc), 64'h0);
    chk("first.id_inst", 64'(IF_ID_inst), 64'h0010_0093);
    chk("first.id_valid", 64'(IF_ID_valid), 64'd1);
    zero_wait_ack();
    cycle("ack4");

    // Stall with a response arriving at 0x8
    chk("stall.addr", 64'(imem_addr), 64'h8);
    zero_wait_ack(); IF_ID_write = 0;
    cycle("stall0");
    imem_ack = 0;
    chk("held.req", 64'(imem_req), 64'd0);
    chk("held.id_pc", 64'(IF_ID_pc), 64'h4);
    imem_ack = 1;
    cycle("stall1");
    imem_ack = 0;
    cycle("stall2");
    IF_ID_write = 1;
    cycle("release");
    chk("release.id_pc", 64'(IF_ID_pc), 64'h8);
    chk("release.addr", 64'(imem_addr), 64'hC);
    zero_wait_ack();
    cycle("ackC");

    // Branch while 0x10 is outstanding; its ack comes two cycles later
    idle(); branch_taken = 1; branch_target = 32'h100;
    cycle("br_out");
    branch_taken = 0;
    chk("br_out.addr", 64'(imem_addr), 64'h10);
    cycle("br_wait");
    zero_wait_ack();
    cycle("br_dropack");
    imem_ack = 0;
    chk("br_drop.valid", 64'(IF_ID_valid), 64'd0);
    chk("br_drop.addr", 64'(imem_addr), 64'h100);
    zero_wait_ack();
    cycle("ack100");

    // Flush beats both stalls
    idle(); branch_taken = 1; branch_target = 32'h100; IF_ID_write = 0; pc_write = 0;
    cycle("flush_stall");
    idle();
    chk("flush.valid", 64'(IF_ID_valid), 64'd0);
    zero_wait_ack();
    cycle("flush_dropack");
    chk("flush.addr", 64'(imem_addr), 64'h100);

    // Branch coincident with an ack, then wrap at the top of the address space
    zero_wait_ack(); branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    cycle("br_ack");
    branch_taken = 0;
    chk("wrap.addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    zero_wait_ack();
    cycle("wrap");
    chk("wrap.id_pc", 64'(IF_ID_pc), 64'hFFFF_FFFC);
    chk("wrap.addr1", 64'(imem_addr), 64'h0);

    // Reset in the middle of an outstanding request
    idle();
    cycle("pre_rst");
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    cycle("in_rst");
    rst_n = 1;
    cycle("rst_boot");
    chk("rst2.req", 64'(imem_req), 64'd1);
    chk("rst2.addr", 64'(imem_addr), 64'h0);

    // Random traffic: variable memory latency, stalls, branches, stray acks
    wait_left = $urandom_range(0, 2);
    for (int i = 0; i < 400; i++) begin
      pc_write      = ($urandom_range(0, 9) != 0);
      IF_ID_write   = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (imem_req) begin
        imem_ack = (wait_left == 0);
        if (wait_left == 0) wait_left = $urandom_range(0, 2);
        else wait_left--;
      end else begin
        imem_ack = ($urandom_range(0, 4) == 0);
      end
      imem_rdata = imem_req ? mem_word(imem_addr) : $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
